// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache controller.
//               Hits complete in the request cycle. Misses are serviced by an
//               FSM that writes back a dirty victim line and fills the new one.
//               Define DCACHE_STATS_EN to build the saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int c_LINES    = 1 << INDEX_BITS;
    localparam int c_TAG_BITS = 13 - INDEX_BITS;

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_WB0   = 4'd1;
    localparam logic [3:0] c_WB1   = 4'd2;
    localparam logic [3:0] c_WB2   = 4'd3;
    localparam logic [3:0] c_WB3   = 4'd4;
    localparam logic [3:0] c_FILL0 = 4'd5;
    localparam logic [3:0] c_FILL1 = 4'd6;
    localparam logic [3:0] c_FILL2 = 4'd7;
    localparam logic [3:0] c_FILL3 = 4'd8;
    localparam logic [3:0] c_RESP  = 4'd9;

    logic [3:0]            r_state;
    logic [c_LINES-1:0]    r_valid;
    logic [c_LINES-1:0]    r_dirty;
    logic [c_TAG_BITS-1:0] r_tag  [c_LINES];
    logic [15:0]           r_data [c_LINES][4];

    logic [INDEX_BITS-1:0] w_index;
    logic [c_TAG_BITS-1:0] w_tag;
    logic [1:0]            w_off;
    logic [1:0]            w_n;
    logic                  w_req;
    logic                  w_illegal;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_idle_miss;
    logic                  w_wb;
    logic                  w_fill;
    logic                  w_resp;

    assign w_index     = Addr[INDEX_BITS+2:3];
    assign w_tag       = Addr[15:INDEX_BITS+3];
    assign w_off       = Addr[2:1];
    assign w_req       = Rd | Wr;
    assign w_illegal   = (Rd & Wr) | (w_req & Addr[0]);
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle_hit  = (r_state == c_IDLE) && w_req && !w_illegal && w_hit;
    assign w_idle_miss = (r_state == c_IDLE) && w_req && !w_illegal && !w_hit;
    assign w_wb        = (r_state >= c_WB0) && (r_state <= c_WB3);
    assign w_fill      = (r_state >= c_FILL0) && (r_state <= c_FILL3);
    assign w_resp      = (r_state == c_RESP);

    // Word number of the current burst beat; offsets wrap inside the line.
    always_comb begin
        w_n = 2'd0;
        case (r_state)
            c_WB1, c_FILL1: w_n = 2'd1;
            c_WB2, c_FILL2: w_n = 2'd2;
            c_WB3, c_FILL3: w_n = 2'd3;
            default:        w_n = 2'd0;
        endcase
    end

    // All outputs are forced low while reset is held.
    always_comb begin
        DataOut   = 16'h0000;
        Stall     = 1'b0;
        Done      = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (rst) begin
            err      = (r_state == c_IDLE) && w_illegal;
            Done     = w_idle_hit || w_resp;
            CacheHit = w_idle_hit;
            Stall    = w_idle_miss || w_wb || w_fill;
            if ((w_idle_hit || w_resp) && Rd) begin
                DataOut = r_data[w_index][w_off];
            end
            if (w_wb) begin
                mem_wr    = 1'b1;
                mem_addr  = {r_tag[w_index], w_index, w_n, 1'b0};
                mem_wdata = r_data[w_index][w_n];
            end else if (w_fill) begin
                mem_rd   = 1'b1;
                mem_addr = {w_tag, w_index, w_n, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_idle_miss) begin
                        // The line is invalid from here until its fill completes.
                        r_valid[w_index] <= 1'b0;
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? c_WB0 : c_FILL0;
                    end else if (w_idle_hit && Wr) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                c_WB0, c_WB1, c_WB2, c_WB3, c_FILL0, c_FILL1, c_FILL2: begin
                    if (mem_ack) begin
                        r_state <= r_state + 4'd1;
                    end
                end
                c_FILL3: begin
                    if (mem_ack) begin
                        r_state          <= c_RESP;
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                c_RESP: begin
                    if (Wr) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_fill && mem_ack) begin
                r_data[w_index][w_n] <= mem_rdata;
            end
            if ((r_state == c_FILL3) && mem_ack) begin
                r_tag[w_index] <= w_tag;
            end
            if ((w_idle_hit || w_resp) && Wr) begin
                r_data[w_index][w_off] <= DataIn;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            if (w_idle_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_idle_miss && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed self-checking bench for dcache_ctrl with a one-cycle
//               ack backing memory that logs every completed transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Stall;
    logic        Done;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack   = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int total = 0;
    int bad   = 0;

`ifdef DCACHE_STATS_EN
    localparam logic [15:0] c_EXP_STAT = 16'd2;
`else
    localparam logic [15:0] c_EXP_STAT = 16'd0;
`endif

    dcache_ctrl #(.INDEX_BITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Stall     (Stall),
        .Done      (Done),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Backing memory: unwritten words read as addr ^ 16'h5A00.
    logic [15:0] mem     [0:32767];
    bit          mem_wrt [0:32767];
    logic        log_wr   [0:255];
    logic [15:0] log_addr [0:255];
    logic [15:0] log_data [0:255];
    int          log_n     = 0;
    logic        both_seen = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mem_ack <= 1'b0;
        end else if ((mem_rd || mem_wr) && !mem_ack) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem_wrt[mem_addr[15:1]] ? mem[mem_addr[15:1]] : (mem_addr ^ 16'h5A00);
        end else begin
            mem_ack <= 1'b0;
        end
        if (rst && mem_ack && (mem_rd || mem_wr) && (log_n < 256)) begin
            log_wr[log_n]   <= mem_wr;
            log_addr[log_n] <= mem_addr;
            log_data[log_n] <= mem_wdata;
            log_n           <= log_n + 1;
            if (mem_wr) begin
                mem[mem_addr[15:1]]     <= mem_wdata;
                mem_wrt[mem_addr[15:1]] <= 1'b1;
            end
        end
        if (mem_rd && mem_wr) both_seen <= 1'b1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Holds a request until Done, then keeps it through the completing edge.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output logic [15:0] dout, output logic hit);
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        lat = -1; dout = 16'h0000; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (Done) begin
                lat = c; dout = DataOut; hit = CacheHit;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({Stall, Done, CacheHit, err, mem_rd, mem_wr} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 000000", {Stall, Done, CacheHit, err, mem_rd, mem_wr});
        end
        total++;
        if ({DataOut, mem_addr, mem_wdata, hit_count, miss_count} !== 80'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {DataOut, mem_addr, mem_wdata, hit_count, miss_count});
        end
    endtask

    task automatic test_cold_read();
        int lat; logic [15:0] dout; logic hit; int base;
        do_reset();
        base = log_n;
        access(1'b1, 1'b0, 16'h0040, 16'h0000, lat, dout, hit);
        total++;
        if (lat !== 9) begin bad++; $display("FAIL cold_lat: got %0d want 9", lat); end
        total++;
        if ({dout, hit} !== {16'h5A40, 1'b0}) begin
            bad++; $display("FAIL cold_data: got %h/%b want 5a40/0", dout, hit);
        end
        total++;
        if (log_n - base !== 4) begin bad++; $display("FAIL cold_count: got %0d want 4", log_n - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_wr[base+i], log_addr[base+i]} !== {1'b0, 16'h0040 + 16'(2*i)}) begin
                bad++; $display("FAIL cold_beat%0d: got %b/%h want 0/%h", i, log_wr[base+i],
                                log_addr[base+i], 16'h0040 + 16'(2*i));
            end
        end
        base = log_n;
        access(1'b1, 1'b0, 16'h0044, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd0, 16'h5A44, 1'b1}) begin
            bad++; $display("FAIL reread_hit: got %0d/%h/%b want 0/5a44/1", lat, dout, hit);
        end
        total++;
        if (log_n !== base) begin bad++; $display("FAIL reread_mem: got %0d want %0d", log_n, base); end
    endtask

    task automatic test_dirty_evict();
        int lat; logic [15:0] dout; logic hit; int base;
        logic [15:0] exp_wd [4];
        exp_wd[0] = 16'h5A40; exp_wd[1] = 16'hBEEF; exp_wd[2] = 16'h5A44; exp_wd[3] = 16'h5A46;
        access(1'b0, 1'b1, 16'h0042, 16'hBEEF, lat, dout, hit);
        total++;
        if ({lat, hit} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL wr_hit: got %0d/%b want 0/1", lat, hit);
        end
        base = log_n;
        access(1'b1, 1'b0, 16'h1040, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd17, 16'h4A40, 1'b0}) begin
            bad++; $display("FAIL evict_resp: got %0d/%h/%b want 17/4a40/0", lat, dout, hit);
        end
        total++;
        if (log_n - base !== 8) begin bad++; $display("FAIL evict_count: got %0d want 8", log_n - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_wr[base+i], log_addr[base+i], log_data[base+i]} !== {1'b1, 16'h0040 + 16'(2*i), exp_wd[i]}) begin
                bad++; $display("FAIL wb_beat%0d: got %b/%h/%h want 1/%h/%h", i, log_wr[base+i],
                                log_addr[base+i], log_data[base+i], 16'h0040 + 16'(2*i), exp_wd[i]);
            end
            total++;
            if ({log_wr[base+4+i], log_addr[base+4+i]} !== {1'b0, 16'h1040 + 16'(2*i)}) begin
                bad++; $display("FAIL refill_beat%0d: got %b/%h want 0/%h", i, log_wr[base+4+i],
                                log_addr[base+4+i], 16'h1040 + 16'(2*i));
            end
        end
    endtask

    task automatic test_stats();
        #1;
        total++;
        if ({hit_count, miss_count} !== {c_EXP_STAT, c_EXP_STAT}) begin
            bad++; $display("FAIL stats: got %0d/%0d want %0d/%0d", hit_count, miss_count, c_EXP_STAT, c_EXP_STAT);
        end
    endtask

    task automatic test_write_alloc();
        int lat; logic [15:0] dout; logic hit; int base;
        do_reset();
        base = log_n;
        access(1'b0, 1'b1, 16'h2008, 16'h1234, lat, dout, hit);
        total++;
        if ({lat, hit} !== {32'd9, 1'b0}) begin
            bad++; $display("FAIL walloc_resp: got %0d/%b want 9/0", lat, hit);
        end
        total++;
        if ({log_wr[base], log_addr[base], log_addr[base+3], 32'(log_n - base)} !==
            {1'b0, 16'h2008, 16'h200E, 32'd4}) begin
            bad++; $display("FAIL walloc_fill: got %b/%h/%h/%0d want 0/2008/200e/4", log_wr[base],
                            log_addr[base], log_addr[base+3], log_n - base);
        end
        access(1'b1, 1'b0, 16'h2008, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd0, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL walloc_read: got %0d/%h/%b want 0/1234/1", lat, dout, hit);
        end
        access(1'b1, 1'b0, 16'h200A, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd0, 16'h7A0A, 1'b1}) begin
            bad++; $display("FAIL walloc_neighbor: got %0d/%h/%b want 0/7a0a/1", lat, dout, hit);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [15:0] dout; logic hit; int base;
        logic [2:0]  v_rw  [3];
        logic [15:0] v_adr [3];
        v_rw[0] = 3'b011; v_adr[0] = 16'h0010;
        v_rw[1] = 3'b010; v_adr[1] = 16'h0011;
        v_rw[2] = 3'b001; v_adr[2] = 16'h2009;
        base = log_n;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            Rd = v_rw[v][1]; Wr = v_rw[v][0]; Addr = v_adr[v]; DataIn = 16'hDEAD;
            for (int c = 0; c < 2; c++) begin
                #1;
                total++;
                if ({err, Done, Stall, mem_rd, mem_wr} !== 5'b10000) begin
                    bad++; $display("FAIL illegal%0d_c%0d: got %b want 10000", v, c, {err, Done, Stall, mem_rd, mem_wr});
                end
                @(negedge clk);
            end
        end
        Rd = 1'b0; Wr = 1'b0;
        total++;
        if (log_n !== base) begin bad++; $display("FAIL illegal_mem: got %0d want %0d", log_n, base); end
        access(1'b1, 1'b0, 16'h2008, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd0, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL illegal_state: got %0d/%h/%b want 0/1234/1", lat, dout, hit);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat; logic [15:0] dout; logic hit; int base; logic found;
        do_reset();
        found = 1'b0;
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0080;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (mem_rd && (mem_addr == 16'h0084)) begin found = 1'b1; break; end
        end
        total++;
        if (found !== 1'b1) begin bad++; $display("FAIL mid_fill_reach: got %b want 1", found); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        Rd = 1'b0;
        total++;
        if ({mem_rd, mem_wr, Stall, Done} !== 4'b0000) begin
            bad++; $display("FAIL mid_fill_rst: got %b want 0000", {mem_rd, mem_wr, Stall, Done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({mem_rd, mem_wr} !== 2'b00) begin
            bad++; $display("FAIL mid_fill_idle: got %b want 00", {mem_rd, mem_wr});
        end
        base = log_n;
        access(1'b1, 1'b0, 16'h0080, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit, 32'(log_n - base)} !== {32'd9, 16'h5A80, 1'b0, 32'd4}) begin
            bad++; $display("FAIL mid_fill_remiss: got %0d/%h/%b/%0d want 9/5a80/0/4", lat, dout, hit, log_n - base);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [15:0] dout; logic hit; int base;
        base = log_n;
        access(1'b1, 1'b0, 16'hFFFE, 16'h0000, lat, dout, hit);
        total++;
        if ({lat, dout, hit} !== {32'd9, 16'hA5FE, 1'b0}) begin
            bad++; $display("FAIL wrap_resp: got %0d/%h/%b want 9/a5fe/0", lat, dout, hit);
        end
        total++;
        if ({log_addr[base], log_addr[base+1], log_addr[base+2], log_addr[base+3]} !==
            {16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE}) begin
            bad++; $display("FAIL wrap_addr: got %h %h %h %h want fff8 fffa fffc fffe", log_addr[base],
                            log_addr[base+1], log_addr[base+2], log_addr[base+3]);
        end
        total++;
        if (both_seen !== 1'b0) begin bad++; $display("FAIL rd_wr_excl: got %b want 0", both_seen); end
    endtask

    initial begin
        rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
        repeat (2) @(posedge clk);
        test_reset();
        test_cold_read();
        test_dirty_evict();
        test_stats();
        test_write_alloc();
        test_illegal();
        test_reset_mid_fill();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
